// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t;

  typedef logic [3:0] key_code_t;

  // Clocks per scan tick. Clamped to at least one clock so the divider never degenerates.
  function automatic int unsigned scan_div(input int unsigned freq, input int unsigned hz);
    return ((freq / hz) < 1) ? 1 : (freq / hz);
  endfunction

endpackage

// File: rtl/input_sync.sv
// Parameterized-width two-flop synchronizer with a configurable asynchronous reset value.
module input_sync #(
  parameter int unsigned           WIDTH   = 4,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce and a valid/ready key-code output.
// Define KEYPAD_REPEAT_EN to build the held-key auto-repeat logic.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned FPGA_FREQ      = 50_000_000,
  parameter int unsigned SCAN_HZ        = 1_000,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_PERIOD  = 100
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  output logic [3:0] col_n_o,
  input  logic [3:0] row_n_i,
  output logic [3:0] key_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       overrun_o
);

  localparam int unsigned      SCAN_DIV = scan_div(FPGA_FREQ, SCAN_HZ);
  localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_TICKS);

  logic [3:0]       row_s;
  logic             tick;
  logic [DIV_W-1:0] div_q, div_d;
  kp_state_t        state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       relcnt_q, relcnt_d;
  key_code_t        key_q, key_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             emit;
  logic             one_low;
  logic [1:0]       low_idx;
  key_code_t        emit_code;

  input_sync #(
    .WIDTH   (4),
    .RST_VAL (4'b1111)
  ) u_row_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (row_n_i),
    .q_o     (row_s)
  );

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  // A capture needs exactly one row low in the active column; ghosting patterns are skipped.
  assign one_low = ($countones(~row_s) == 1);

  always_comb begin
    low_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) low_idx = 2'(i);
    end
  end

  assign emit_code = {row_idx_q, col_q};

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] REP_DLY = 16'(REPEAT_DELAY);
  localparam logic [15:0] REP_PER = 16'(REPEAT_PERIOD);

  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic        rep_arm_q, rep_arm_d;
  logic [15:0] rep_nxt;

  assign rep_nxt = rep_cnt_q + 16'd1;
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_idx_d = row_idx_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    relcnt_d  = relcnt_q;
    emit      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
    rep_arm_d = rep_arm_q;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (one_low) begin
            state_d   = DEBOUNCE;
            row_idx_d = low_idx;
            pat_d     = row_s;
            cnt_d     = 4'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_s == pat_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == DEB_N) begin
              emit     = 1'b1;
              state_d  = HELD;
              relcnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_d = '0;
              rep_arm_d = 1'b0;
`endif
            end
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        HELD: begin
          // Column stays frozen here, so other keys in it only keep the hold alive.
          if (&row_s) begin
            relcnt_d = relcnt_q + 4'd1;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d = '0;
            rep_arm_d = 1'b0;
`endif
            if (relcnt_d == DEB_N) begin
              state_d  = SCAN;
              col_d    = col_q + 2'd1;
              relcnt_d = '0;
            end
          end else begin
            relcnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            if ((!rep_arm_q && rep_nxt == REP_DLY) || (rep_arm_q && rep_nxt == REP_PER)) begin
              emit      = 1'b1;
              rep_cnt_d = '0;
              rep_arm_d = 1'b1;
            end else begin
              rep_cnt_d = rep_nxt;
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // A pending, unaccepted code wins over a new one; a same-cycle accept frees the slot.
  always_comb begin
    key_d     = key_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (emit) begin
      if (valid_q && !ready_i) begin
        overrun_d = 1'b1;
      end else begin
        key_d   = emit_code;
        valid_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q     <= '0;
      state_q   <= SCAN;
      col_q     <= '0;
      row_idx_q <= '0;
      pat_q     <= 4'b1111;
      cnt_q     <= '0;
      relcnt_q  <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      state_q   <= state_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      pat_q     <= pat_d;
      cnt_q     <= cnt_d;
      relcnt_q  <= relcnt_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rep_cnt_q <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
    end
  end
`endif

  assign col_n_o   = ~(4'b0001 << col_q);
  assign key_o     = key_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule
